// File: rtl/di_queue_if.sv
// Decoded-instruction type and the decoder-to-dispatch handshake interface of di_queue.
package C;
  typedef struct packed {
    logic [7:0]  id;
    logic        fault;
    logic [22:0] payload;
  } di_t;
endpackage

interface di_queue_if;
  C::di_t di_i;
  logic   valid_i;
  logic   ready_o;
  C::di_t di_o;
  logic   valid_o;
  logic   ready_i;

  modport slave  (input di_i, valid_i, ready_i, output ready_o, di_o, valid_o);
  modport master (output di_i, valid_i, ready_i, input ready_o, di_o, valid_o);
endinterface

// File: rtl/di_queue.sv
// FIFO of decoded instructions between the decoder and dispatch.
// Intake locks after a faulting instruction until flush.
module di_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush_i,
  di_queue_if.slave                q,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     fault_lock_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  C::di_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop;

  // ready_o ignores ready_i: a full queue never accepts, even while popping
  assign q.ready_o = (count_o != CW'(DEPTH)) && !fault_lock_o && !flush_i;
  assign q.valid_o = (count_o != '0);
  assign q.di_o    = rstn ? mem[rd_ptr] : '0;

  assign push = q.valid_i && q.ready_o;
  assign pop  = q.valid_o && q.ready_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_o      <= '0;
      fault_lock_o <= 1'b0;
    end else if (flush_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_o      <= '0;
      fault_lock_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_o <= count_o + CW'(1);
        2'b01:   count_o <= count_o - CW'(1);
        default: count_o <= count_o;
      endcase
      if (push && q.di_i.fault) fault_lock_o <= 1'b1;
    end
  end

  // storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= q.di_i;
  end
endmodule

// File: tb/tb_di_queue.sv
// Bench for di_queue: directed vector table, hand sequences, and random traffic vs a queue model.
module tb_di_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rstn, flush;
  logic [$clog2(DEPTH):0] count;
  logic lock;
  int checks = 0, errors = 0;

  di_queue_if q();

  di_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .flush_i(flush), .q(q),
    .count_o(count), .fault_lock_o(lock)
  );

  always #5 clk = ~clk;

  a_full:  assert property (@(posedge clk) disable iff (!rstn) !(q.valid_i && q.ready_o && count == DEPTH));
  a_empty: assert property (@(posedge clk) disable iff (!rstn) !(q.valid_o && q.ready_i && count == 0));
  a_max:   assert property (@(posedge clk) disable iff (!rstn) count <= DEPTH);
  a_hold:  assert property (@(posedge clk) disable iff (!rstn) (q.valid_i && !q.ready_o && !flush) |=> q.valid_i);

  typedef struct {
    bit v, f, r, fl;
    int id;
    int ecnt;
    bit evo, ero, elk;
    int eid;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(bit v, bit f, int id, bit r, bit fl,
                              int ecnt, bit evo, bit ero, bit elk, int eid);
    vec_t t;
    t.v = v; t.f = f; t.id = id; t.r = r; t.fl = fl;
    t.ecnt = ecnt; t.evo = evo; t.ero = ero; t.elk = elk; t.eid = eid;
    return t;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(bit v, bit f, int id, bit r, bit fl);
    C::di_t d;
    d.id = id[7:0];
    d.fault = f;
    d.payload = 23'($urandom);
    q.di_i = d;
    q.valid_i = v;
    q.ready_i = r;
    flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  C::di_t mq[$];
  bit     mlock;

  initial begin
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(q.valid_o), 0);
    chk("rst_ready", 32'(q.ready_o), 1);
    chk("rst_lock",  32'(lock), 0);
    chk("rst_di",    32'(q.di_o), 0);
    rstn = 1'b1;

    //          v f id r fl  cnt vo ro lk id
    tbl[0]  = mk(1,0,1, 0,0,  1, 1, 1, 0, 1);
    tbl[1]  = mk(1,0,2, 0,0,  2, 1, 1, 0, 1);
    tbl[2]  = mk(1,0,3, 0,0,  3, 1, 1, 0, 1);
    tbl[3]  = mk(1,0,4, 0,0,  4, 1, 0, 0, 1);
    tbl[4]  = mk(1,0,5, 0,0,  4, 1, 0, 0, 1);
    tbl[5]  = mk(1,0,5, 1,0,  3, 1, 1, 0, 2);
    tbl[6]  = mk(1,0,5, 1,0,  3, 1, 1, 0, 3);
    tbl[7]  = mk(0,0,0, 1,0,  2, 1, 1, 0, 4);
    tbl[8]  = mk(0,0,0, 1,0,  1, 1, 1, 0, 5);
    tbl[9]  = mk(0,0,0, 1,0,  0, 0, 1, 0, 0);
    tbl[10] = mk(1,0,5, 0,0,  1, 1, 1, 0, 5);
    tbl[11] = mk(1,0,6, 0,0,  2, 1, 1, 0, 5);
    tbl[12] = mk(1,1,7, 0,0,  3, 1, 0, 1, 5);
    tbl[13] = mk(1,0,8, 0,0,  3, 1, 0, 1, 5);
    tbl[14] = mk(1,0,8, 1,0,  2, 1, 0, 1, 6);
    tbl[15] = mk(1,0,8, 1,0,  1, 1, 0, 1, 7);
    tbl[16] = mk(1,0,8, 1,0,  0, 0, 0, 1, 0);
    tbl[17] = mk(1,0,8, 1,0,  0, 0, 0, 1, 0);
    tbl[18] = mk(1,0,8, 1,1,  0, 0, 0, 0, 0);
    tbl[19] = mk(0,0,0, 0,0,  0, 0, 1, 0, 0);
    tbl[20] = mk(1,0,9, 0,0,  1, 1, 1, 0, 9);
    tbl[21] = mk(0,0,0, 1,0,  0, 0, 1, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].f, tbl[i].id, tbl[i].r, tbl[i].fl);
      tick();
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].ecnt));
      chk($sformatf("vec%0d_valid", i), 32'(q.valid_o), 32'(tbl[i].evo));
      chk($sformatf("vec%0d_ready", i), 32'(q.ready_o), 32'(tbl[i].ero));
      chk($sformatf("vec%0d_lock",  i), 32'(lock), 32'(tbl[i].elk));
      if (tbl[i].evo) chk($sformatf("vec%0d_id", i), 32'(q.di_o.id), 32'(tbl[i].eid));
    end

    // streaming: one in, one out per cycle, pointers wrap twice
    for (int k = 0; k < 10; k++) begin
      drive(1, 0, k, 1, 0);
      tick();
      chk($sformatf("stream%0d_count", k), 32'(count), 1);
      chk($sformatf("stream%0d_id", k), 32'(q.di_o.id), 32'(k));
    end
    drive(0, 0, 0, 1, 0);
    tick();
    chk("stream_drain", 32'(count), 0);

    // flush with three entries, a push offered and a head pop in the same cycle
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 20 + k, 0, 0);
      tick();
    end
    drive(1, 0, 23, 1, 1);
    #1;
    chk("flush_pop_valid", 32'(q.valid_o), 1);
    chk("flush_pop_id", 32'(q.di_o.id), 20);
    chk("flush_ready", 32'(q.ready_o), 0);
    tick();
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(q.valid_o), 0);
    drive(1, 0, 23, 1, 1);
    tick();
    chk("flush2_count", 32'(count), 0);
    drive(0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("flush_after%0d_valid", k), 32'(q.valid_o), 0);
    end

    // asynchronous reset mid-cycle with two entries held
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 30 + k, 0, 0);
      tick();
    end
    chk("arst_pre_count", 32'(count), 2);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_valid", 32'(q.valid_o), 0);
    chk("arst_di", 32'(q.di_o), 0);
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    drive(1, 0, 40, 0, 0);
    tick();
    chk("arst_post_count", 32'(count), 1);
    chk("arst_post_id", 32'(q.di_o.id), 40);

    // random traffic against a queue model
    drive(0, 0, 0, 0, 1);
    tick();
    mq.delete();
    mlock = 1'b0;
    begin
      bit     hold = 1'b0;
      bit     v, r, fl, eready, push, pop;
      C::di_t d;
      logic [7:0] nid = 8'd100;
      for (int c = 0; c < 600; c++) begin
        fl = ($urandom_range(0, 39) == 0);
        r  = ($urandom_range(0, 3) != 0);
        if (!hold) begin
          v = ($urandom_range(0, 2) != 0);
          d.id = nid;
          d.fault = ($urandom_range(0, 15) == 0);
          d.payload = 23'($urandom);
          nid = nid + 8'd1;
        end
        q.di_i = d; q.valid_i = v; q.ready_i = r; flush = fl;
        #1;
        eready = (mq.size() != DEPTH) && !mlock && !fl;
        chk("rnd_count", 32'(count), 32'(mq.size()));
        chk("rnd_valid", 32'(q.valid_o), 32'(mq.size() != 0));
        chk("rnd_ready", 32'(q.ready_o), 32'(eready));
        chk("rnd_lock",  32'(lock), 32'(mlock));
        if (mq.size() != 0) chk("rnd_di", 32'(q.di_o), 32'(mq[0]));
        push = v && eready;
        pop  = (mq.size() != 0) && r;
        hold = v && !push && !fl;
        tick();
        if (fl) begin
          mq.delete();
          mlock = 1'b0;
        end else begin
          if (pop) void'(mq.pop_front());
          if (push) begin
            mq.push_back(d);
            if (d.fault) mlock = 1'b1;
          end
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/di_queue.md
Name: di_queue

Overview:
- Buffers decoded instructions (C::di_t) between the dynamic decoder and the issue/dispatch stage.
- Decouples decoder throughput from dispatch back-pressure using a valid/ready handshake on both sides.
- Once a faulting instruction has been accepted, intake stops until the pipeline is flushed.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous flush; discards all entries.
- di_i  input  $bits(C::di_t)  decoded instruction from the dynamic decoder.
- valid_i  input  1  di_i is valid.
- ready_o  output  1  queue accepts di_i this cycle.
- di_o  output  $bits(C::di_t)  head entry.
- valid_o  output  1  di_o holds a valid entry.
- ready_i  input  1  consumer takes di_o this cycle.
- count_o  output  $clog2(DEPTH)+1  number of occupied entries.
- fault_lock_o  output  1  a faulted entry has been accepted and no flush has occurred since.

Behaviour:
- Reset (rstn=0, asynchronous): wr_ptr=0, rd_ptr=0, count_o=0, valid_o=0, fault_lock_o=0, ready_o=1.
  - di_o = '0 while in reset.
  - Storage array is not reset.
- Push = valid_i && ready_o. Pop = valid_o && ready_i. Both are evaluated on the same rising edge.
- ready_o = (count_o != DEPTH) && !fault_lock_o && !flush_i. It is combinational from registered state and flush_i only; it never depends on ready_i.
  - There is no pass-through when full: a pop in the same cycle does not open a slot for a push.
- valid_o = (count_o != 0). di_o = storage[rd_ptr].
  - di_o content is don't-care when valid_o=0.
  - di_o and valid_o depend only on registers (no combinational path from di_i/valid_i).
- Latency:
  - A pushed entry is visible at di_o no earlier than the next cycle.
  - Entering an empty queue at edge N gives valid_o=1 in cycle N+1.
- Ordering: strict FIFO; entries are never reordered, duplicated or modified. di_o.id equals di_i.id at push time.
- Pointers: log2(DEPTH) bits; wrap from DEPTH-1 to 0 naturally.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: unchanged (possible whenever 0 < count_o < DEPTH).
- Fault lock:
  - On a push with di_i.fault=1, fault_lock_o becomes 1 on the next cycle and ready_o drops to 0.
  - The faulted entry itself is stored and drains normally, as do entries already ahead of it.
  - Entries pushed in earlier cycles are unaffected.
  - The lock persists after the queue empties; only flush_i or reset clears it.
- Flush (flush_i=1 at an edge): next cycle count_o=0, valid_o=0, rd_ptr=wr_ptr=0, fault_lock_o=0.
  - A push in the flush cycle is ignored (ready_o is already 0).
  - A pop in the flush cycle is permitted, and the consumer sees that handshake complete.
  - flush_i dominates every other update.
  - Consecutive flush cycles keep the queue empty.
- Reset asserted mid-operation: all state returns to reset values immediately; contents are lost.
- Assertions (verification):
  - No push when count_o==DEPTH.
  - No pop when count_o==0.
  - count_o never exceeds DEPTH.
  - Once valid_i=1 is presented, the decoder holds it until ready_o.

Test Plan:
- Reset, then push ids 1,2,3 on back-to-back cycles with ready_i=0.
  -> count_o = 1,2,3 on successive cycles; valid_o=1 from the cycle after the first push; di_o.id=1.
- DEPTH=4, keep valid_i=1 with ready_i=0.
  -> after 4 pushes count_o=4 and ready_o=0.
  -> assert ready_i=1 for 1 cycle: pop id 1, count_o=3, ready_o=1, no push in the pop cycle.
- Continuous push and pop, ids 0..9, with ready_i=1 from cycle 1.
  -> output ids 0..9 in order, one per cycle after a 1-cycle fill latency.
  -> count_o steady at 1; pointers wrap twice with no loss.
- Push ids 5,6 (fault=0), then 7 (fault=1), then offer id 8.
  -> ready_o=0 from the cycle after 7 is accepted; 8 is never accepted.
  -> 5,6,7 drain in order; fault_lock_o stays 1 with the queue empty.
  -> flush_i pulse: fault_lock_o=0, ready_o=1 the next cycle.
- Queue holding 3 entries; flush_i=1 with valid_i=1 and ready_i=1.
  -> the head pop completes; next cycle count_o=0, valid_o=0.
  -> the offered entry is never seen at di_o.
- Queue holding 2 entries; drop rstn asynchronously mid-cycle.
  -> valid_o=0 and count_o=0 immediately, before the next clk edge.
  -> after release, the first pushed id appears at di_o.
